button_event_arbiter: RTL
=========================

# button_event_arbiter

Debounces a bank of push buttons on the slow scan clock and turns each debounced press into a one-entry event code. Events from simultaneous presses are serialized by a round-robin arbiter into a small FIFO. A valid/ready handshake drains the FIFO. The block sits between the raw board buttons and the control FSMs, replacing per-button debounce-and-pulse instances.

## Interface
- N_BTN, 4: number of buttons, 2..16.
- STABLE_CNT, 3: consecutive CLK_190 samples a synchronized input must differ from the debounced state before the state flips, 1..15.
- FIFO_DEPTH, 4: event FIFO entries, power of two, ≥2.
- CLK_190 input 1: scan clock. Single clock domain.
- RESET input 1: asynchronous, active-high reset.
- BTN input N_BTN: raw button levels, asynchronous, 1 = pressed.
- EV_READY input 1: consumer accepts the head event this cycle.
- EV_VALID output 1: FIFO non-empty. Reset 0.
- EV_CODE output CODE_W: index of the pressed button at the FIFO head. Reset 0. CODE_W = max(1, clog2(N_BTN)).
- BTN_STATE output N_BTN: debounced levels. Reset 0.
- EV_OVERFLOW output 1: sticky flag indicating a press was dropped. Reset 0. Cleared only by RESET.

## Operation
- Per button, the input passes through a 2-flop synchronizer, then a stability counter.
  - Counter increments while the synchronized value differs from BTN_STATE[i].
  - Counter clears to 0 when the two are equal.
  - When the counter would reach STABLE_CNT, BTN_STATE[i] takes the synchronized value and the counter clears.
- A 0→1 flip of BTN_STATE[i] sets pending[i] on the same edge. A 1→0 flip produces no event.
- If pending[i] is already 1 when a new 0→1 flip occurs, set EV_OVERFLOW. The press is dropped and pending[i] stays 1.
- Arbiter:
  - Combinational round-robin grant over pending, searching from last_grant+1 upward with wrap.
  - last_grant resets to N_BTN-1, so button 0 has first priority.
  - On a grant with push allowed:
    - write the granted index to the FIFO;
    - clear pending[grant];
    - set last_grant to grant.
  - At most one push per cycle.
- Push is allowed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - When push is not allowed, pending bits simply wait. No overflow is raised for a full FIFO.
- FIFO behaviour:
  - First-word-fall-through: EV_CODE always shows the head entry.
  - Pop occurs when EV_VALID & EV_READY.
  - EV_READY while empty is ignored.
  - Pointers are log2(FIFO_DEPTH)+1 bits, so full/empty are decided by the MSB.
- Reset mid-operation: all synchronizers, counters, pending bits, FIFO pointers, last_grant and EV_OVERFLOW go to 0 / reset value immediately. Queued events are discarded.

## Timing
- Press latency: BTN first sampled high at edge k, and held stable:
  - sync2 goes high at k+1;
  - BTN_STATE and pending go high at k+1+STABLE_CNT;
  - FIFO write happens at k+2+STABLE_CNT;
  - EV_VALID goes high after edge k+2+STABLE_CNT (5 edges for STABLE_CNT=3, FIFO empty, no competing pending bits).
- A bounce shorter than STABLE_CNT samples after sync2 never changes BTN_STATE.
- Pop at edge e: the next entry appears on EV_CODE after e. EV_VALID falls after e if the popped entry was the last.
- A simultaneous push and pop on an empty FIFO is impossible, since pop requires EV_VALID. On a full FIFO both occur and the count is unchanged.
- Multiple pending bits drain one per cycle.

## Structure
- No shared package. CODE_W and pointer width are localparams computed inside the block.
- Sub-module btn_filter: synchronizer, stability counter and BTN_STATE flop for one button, plus a rise output. Instantiated N_BTN times by generate.
- Arbiter, pending register and FIFO stay in the top module.

## Test plan
- Clean press of BTN[2] held 10 cycles, EV_READY=1 → EV_VALID high 1 cycle after edge k+5, EV_CODE=2, single event, BTN_STATE[2]=1.
- BTN[1] bounces as 1,0,1,0 on successive edges, then holds 1 → exactly one event with code 1; no BTN_STATE change during the bounce.
- BTN[0] and BTN[3] pressed on the same edge, EV_READY=1 → events 0 then 3 on consecutive cycles. Next simultaneous pair yields 0 then 3 again only if last_grant=3; a pair BTN[3],BTN[1] after last_grant=0 yields 1 then 3.
- EV_READY=0; press buttons 0,1,2,3,0 sequentially (each released and re-debounced) → FIFO holds 0,1,2,3 and pending[0]=1. A further press of 0 sets EV_OVERFLOW=1. Raising EV_READY drains 0,1,2,3,0.
- Full FIFO with pending[1]=1 and EV_READY=1 for one cycle → pop and push on the same edge; count stays 4; the tail gains code 1.
- RESET asserted mid-queue with 3 entries → EV_VALID, BTN_STATE and EV_OVERFLOW go to 0 asynchronously. After release, a held button produces a new event only after the full 5-cycle latency.

Source files
------------

// File: rtl/btn_filter.sv
// rtl/btn_filter.sv - synchronizer and stability-count debouncer for one button
module btn_filter #(
  parameter int STABLE_CNT = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic state_o,
  output logic rise_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       state_q;
  logic       state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       flip;

  // Counter only runs while the synchronized level disagrees with the debounced one.
  always_comb begin
    cnt_d   = 4'd0;
    state_d = state_q;
    flip    = 1'b0;
    if (sync2_q != state_q) begin
      if (cnt_q + 4'd1 == 4'(STABLE_CNT)) begin
        flip    = 1'b1;
        state_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;
  assign rise_o  = flip & sync2_q;

endmodule

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - debounced button presses serialized into an event FIFO
module button_event_arbiter #(
  parameter int N_BTN      = 4,
  parameter int STABLE_CNT = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int CODE_W    = (N_BTN > 2) ? $clog2(N_BTN) : 1
) (
  input  logic              CLK_190,
  input  logic              RESET,
  input  logic [N_BTN-1:0]  BTN,
  input  logic              EV_READY,
  output logic              EV_VALID,
  output logic [CODE_W-1:0] EV_CODE,
  output logic [N_BTN-1:0]  BTN_STATE,
  output logic              EV_OVERFLOW
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;

  logic [N_BTN-1:0]  rise;
  logic [N_BTN-1:0]  pending_q, pending_d;
  logic [CODE_W-1:0] last_grant_q, last_grant_d;
  logic [CODE_W-1:0] grant_idx;
  logic              grant_vld;
  logic              overflow_q, overflow_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic              full, empty, push, pop;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_filter #(.STABLE_CNT(STABLE_CNT)) u_filt (
      .clk_i   (CLK_190),
      .rst_i   (RESET),
      .btn_i   (BTN[g]),
      .state_o (BTN_STATE[g]),
      .rise_o  (rise[g])
    );
  end

  // Round-robin search starts one past the last granted button and wraps.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int off = 1; off <= N_BTN; off++) begin
      idx = int'(last_grant_q) + off;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (!grant_vld && |(pending_q & (N_BTN'(1) << idx))) begin
        grant_vld = 1'b1;
        grant_idx = CODE_W'(idx);
      end
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = ~empty & EV_READY;
  assign push  = grant_vld & (~full | pop);

  always_comb begin
    pending_d = pending_q;
    if (push) pending_d = pending_d & ~(N_BTN'(1) << grant_idx);
    // A press on an already-pending button is dropped rather than re-armed.
    pending_d    = pending_d | (rise & ~pending_q);
    overflow_d   = overflow_q | (|(rise & pending_q));
    last_grant_d = push ? grant_idx : last_grant_q;
  end

  always_ff @(posedge CLK_190 or posedge RESET) begin
    if (RESET) begin
      pending_q    <= '0;
      last_grant_q <= CODE_W'(N_BTN - 1);
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      overflow_q   <= overflow_d;
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= grant_idx;
        wr_ptr_q                <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  assign EV_VALID    = ~empty;
  assign EV_CODE     = mem_q[rd_ptr_q[AW-1:0]];
  assign EV_OVERFLOW = overflow_q;

endmodule
